// File: rtl/pipe_dmem_responder.sv
// Data-memory responder for the MEM stage of the 5-stage pipelined CPU.
// Latency: response (rvalid) in the cycle after edge N+LATENCY, or after edge N for bad addresses.
// Backpressure: one request in flight; req_ready low and stall high until the response cycle.
//
// Ports:
//   clk, rst          - rising-edge clock, asynchronous active-high reset
//   dfileid           - bank select (8 banks), sampled at accept
//   req_valid/req_we  - request present / 1 = store, 0 = load
//   req_addr          - byte address
//   req_wdata         - store data
//   req_ready         - high while idle (a request can be accepted)
//   stall             - combinational pipeline freeze
//   rdata             - registered load data
//   rvalid, err       - one-cycle response strobe and its error flag
//   err_count         - saturating count of error responses
module pipe_dmem_responder #(
   parameter int DEPTH_LOG2 = 8,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  dfileid,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        rvalid,
   output logic        err,
   output logic [7:0]  err_count
);

   localparam int WORDS = 1 << DEPTH_LOG2;
   localparam int IDXW  = DEPTH_LOG2 + 3;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                  state;
   logic [3:0]              cnt;
   logic                    cap_we;
   logic                    cap_err;
   logic [2:0]              cap_bank;
   logic [DEPTH_LOG2-1:0]   cap_word;
   logic [31:0]             cap_wdata;

   // All banks live in one array; the bank number forms the top index bits.
   logic [31:0] mem [0:8*WORDS-1];

   logic            err_hit;
   logic            direct;
   logic            finish;
   logic            fire;
   logic            op_we;
   logic            op_err;
   logic [31:0]     op_wdata;
   logic [IDXW-1:0] op_idx;

   // Misaligned, or beyond the last word of a bank (no wrap-around).
   assign err_hit = (req_addr[1:0] != 2'b00) | (req_addr[31:DEPTH_LOG2+2] != '0);

   // The access happens on the edge entering RESP. On the zero-wait paths that
   // edge is the accept edge itself, so the live request is used instead of
   // the captured copy.
   assign direct = (state == IDLE) && req_valid && (err_hit || (LATENCY == 0));
   assign finish = (state == WAIT) && (cnt == 4'd0);
   assign fire   = direct || finish;

   always_comb begin
      op_we    = cap_we;
      op_err   = cap_err;
      op_wdata = cap_wdata;
      op_idx   = {cap_bank, cap_word};
      if (direct) begin
         op_we    = req_we;
         op_err   = err_hit;
         op_wdata = req_wdata;
         op_idx   = {dfileid, req_addr[DEPTH_LOG2+1:2]};
      end
   end

   assign req_ready = (state == IDLE);
   assign stall     = ((state == IDLE) && req_valid) || (state == WAIT);

   // Storage is not reset; a write is suppressed while rst is asserted so a
   // store interrupted by reset never lands.
   always_ff @(posedge clk) begin
      if (!rst && fire && op_we && !op_err) begin
         mem[op_idx] <= op_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         cap_we    <= 1'b0;
         cap_err   <= 1'b0;
         cap_bank  <= 3'd0;
         cap_word  <= '0;
         cap_wdata <= 32'd0;
         rdata     <= 32'd0;
         rvalid    <= 1'b0;
         err       <= 1'b0;
         err_count <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  cap_we    <= req_we;
                  cap_err   <= err_hit;
                  cap_bank  <= dfileid;
                  cap_word  <= req_addr[DEPTH_LOG2+1:2];
                  cap_wdata <= req_wdata;
                  if (err_hit || (LATENCY == 0)) begin
                     state <= RESP;
                  end else begin
                     state <= WAIT;
                     cnt   <= 4'(LATENCY - 1);
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  state <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase

         rvalid <= fire;
         err    <= fire && op_err;
         if (fire) begin
            if (op_err) begin
               rdata <= 32'd0;
               if (err_count != 8'hFF) begin
                  err_count <= err_count + 8'd1;
               end
            end else if (!op_we) begin
               rdata <= mem[op_idx];
            end
         end
      end
   end

endmodule
